// File: rtl/arb_mux2_if.sv
// arb_mux2_if -- bundle of the two-source arbiter's request/data/grant signals.
//
// Signals:
//   req_a/req_b     source requests a beat (held while data is valid)
//   data_a/data_b   source data, WIDTH bits
//   last_a/last_b   final beat of a packet, meaningful only on a beat
//   grant_a/grant_b registered grants, one-hot or zero
//   sel             registered mux select, 0 = A, 1 = B
//   y, valid        registered muxed data and its beat qualifier
//   cnt_a/cnt_b     completed-grant counters (zero unless statistics are built in)
//
// Modports: slave = the arbiter, master = whatever drives the sources.
interface arb_mux2_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             last_a;
  logic             last_b;
  logic             grant_a;
  logic             grant_b;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             valid;
  logic [15:0]      cnt_a;
  logic [15:0]      cnt_b;

  modport slave (
    input  req_a, req_b, data_a, data_b, last_a, last_b,
    output grant_a, grant_b, sel, y, valid, cnt_a, cnt_b
  );

  modport master (
    output req_a, req_b, data_a, data_b, last_a, last_b,
    input  grant_a, grant_b, sel, y, valid, cnt_a, cnt_b
  );
endinterface

// File: rtl/arb_mux2.sv
// arb_mux2 -- two-source packet arbiter with registered data mux.
//
// A grant is held for a whole packet (until last_x), but is forcibly rotated
// after MAX_HOLD beats when the other side is waiting. Ties from IDLE go to
// the side named by a priority pointer that always points at the side that
// was not served most recently. Grants, select and data are all registered.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   arb_mux2_if.slave (requests, data, last, grants, sel, y, valid, counters)
//
// Parameters:
//   WIDTH     data width
//   MAX_HOLD  beats per grant before rotation under contention (1..255)
//
// Optional feature: define ARB_MUX2_STATS_EN to build the saturating
// completed-grant counters cnt_a/cnt_b; otherwise they read constant zero.
module arb_mux2 #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  arb_mux2_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             prio_q, prio_d;     // 0 = A wins a tie, 1 = B wins a tie
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             grant_a_q, grant_b_q;

  // Current owner's view of the bus; only meaningful in GNT_A / GNT_B.
  logic             served_b;
  logic             own_req, own_last, other_req;
  logic [WIDTH-1:0] own_data;
  logic             grant_end;

  assign served_b  = (state_q == GNT_B);
  assign own_req   = served_b ? bus.req_b  : bus.req_a;
  assign own_last  = served_b ? bus.last_b : bus.last_a;
  assign own_data  = served_b ? bus.data_b : bus.data_a;
  assign other_req = served_b ? bus.req_a  : bus.req_b;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    prio_d    = prio_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    grant_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || !prio_q)) begin
          state_d = GNT_A;
          hold_d  = '0;
        end else if (bus.req_b) begin
          state_d = GNT_B;
          hold_d  = '0;
        end
      end

      GNT_A, GNT_B: begin
        if (!own_req) begin
          // Source withdrew: grant ends without a beat, y holds.
          grant_end = 1'b1;
        end else begin
          y_d     = own_data;
          valid_d = 1'b1;
          if (own_last || (hold_q == HOLD_LAST && other_req)) begin
            grant_end = 1'b1;
          end else if (hold_q == HOLD_LAST) begin
            // Limit reached but nobody is waiting: start a fresh window.
            hold_d = '0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end

        if (grant_end) begin
          prio_d  = ~served_b;
          hold_d  = '0;
          // Hand over directly when the other side waits, no IDLE bubble.
          state_d = other_req ? (served_b ? GNT_A : GNT_B) : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    sel_d = sel_q;
    if (state_d == GNT_A) sel_d = 1'b0;
    if (state_d == GNT_B) sel_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      prio_q    <= 1'b0;
      sel_q     <= 1'b0;
      valid_q   <= 1'b0;
      y_q       <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      prio_q    <= prio_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      y_q       <= y_d;
      grant_a_q <= (state_d == GNT_A);
      grant_b_q <= (state_d == GNT_B);
    end
  end

  assign bus.grant_a = grant_a_q;
  assign bus.grant_b = grant_b_q;
  assign bus.sel     = sel_q;
  assign bus.valid   = valid_q;
  assign bus.y       = y_q;

`ifdef ARB_MUX2_STATS_EN
  logic [15:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (grant_end) begin
      if (!served_b && cnt_a_q != 16'hFFFF) cnt_a_q <= cnt_a_q + 16'd1;
      if (served_b  && cnt_b_q != 16'hFFFF) cnt_b_q <= cnt_b_q + 16'd1;
    end
  end

  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
`else
  assign bus.cnt_a = 16'h0000;
  assign bus.cnt_b = 16'h0000;
`endif

endmodule

// File: tb/tb_arb_mux2.sv
// tb_arb_mux2 -- self-checking bench for arb_mux2.
// A behavioural bus-ownership model tracks who owns the bus, how many beats
// the current window has used and who wins the next tie; a negedge process
// compares every DUT output against it each cycle. Directed scenarios add
// hand-computed literal expectations, followed by a long random phase.
module tb_arb_mux2;
  localparam int WIDTH = 8;
  localparam int MH    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_mux2_if #(.WIDTH(WIDTH)) bus ();

  arb_mux2 #(.WIDTH(WIDTH), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Model: owner 0 = nobody, 1 = A, 2 = B; prio = side index winning a tie.
  int         m_owner = 0;
  int         m_beats = 0;
  int         m_prio  = 0;
  logic [7:0] m_y     = '0;
  bit         m_valid = 1'b0;
  bit         m_sel   = 1'b0;
  int         m_cnt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         req [2];
    logic [7:0] dat [2];
    bit         lst [2];
    int         s;
    bit         done;
    req[0] = bus.req_a;  req[1] = bus.req_b;
    dat[0] = bus.data_a; dat[1] = bus.data_b;
    lst[0] = bus.last_a; lst[1] = bus.last_b;
    if (rst) begin
      m_owner = 0; m_beats = 0; m_prio = 0;
      m_y = '0; m_valid = 0; m_sel = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      return;
    end
    m_valid = 0;
    if (m_owner == 0) begin
      if (req[0] && req[1]) m_owner = m_prio + 1;
      else if (req[0])      m_owner = 1;
      else if (req[1])      m_owner = 2;
      m_beats = 0;
    end else begin
      s    = m_owner - 1;
      done = !req[s];
      if (req[s]) begin
        m_y     = dat[s];
        m_valid = 1;
        m_beats++;
        done = lst[s] || (m_beats == MH && req[1-s]);
        if (!done && m_beats == MH) m_beats = 0;
      end
      if (done) begin
        if (m_cnt[s] < 16'hFFFF) m_cnt[s]++;
        m_prio  = 1 - s;
        m_beats = 0;
        m_owner = req[1-s] ? (2 - s) : 0;
      end
    end
    if (m_owner != 0) m_sel = (m_owner == 2);
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("grant_a", bus.grant_a, 32'(m_owner == 1));
      check("grant_b", bus.grant_b, 32'(m_owner == 2));
      check("sel",     bus.sel,     32'(m_sel));
      check("valid",   bus.valid,   32'(m_valid));
      check("y",       bus.y,       32'(m_y));
`ifdef ARB_MUX2_STATS_EN
      check("cnt_a",   bus.cnt_a,   32'(m_cnt[0]));
      check("cnt_b",   bus.cnt_b,   32'(m_cnt[1]));
`else
      check("cnt_a",   bus.cnt_a,   32'd0);
      check("cnt_b",   bus.cnt_b,   32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit ra, input logic [7:0] da, input bit la,
                       input bit rb, input logic [7:0] db, input bit lb);
    bus.req_a = ra; bus.data_a = da; bus.last_a = la;
    bus.req_b = rb; bus.data_b = db; bus.last_b = lb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    m_cnt[0] = 0; m_cnt[1] = 0;
    do_reset();
    check("reset_grant_a", bus.grant_a, 0);
    check("reset_valid",   bus.valid,   0);
    check("reset_y",       bus.y,       0);

    // Single A beat with last.
    drive(1, 8'h11, 1, 0, 8'h00, 0);
    tick();
    check("one_beat_grant_a", bus.grant_a, 1);
    check("one_beat_no_valid_yet", bus.valid, 0);
    tick();
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    check("one_beat_y", bus.y, 8'h11);
    check("one_beat_valid", bus.valid, 1);
    check("one_beat_idle", bus.grant_a, 0);
    tick();
    check("one_beat_valid_drops", bus.valid, 0);

    // Contention with single-beat packets: strict alternation A,B,A,B.
    do_reset();
    drive(1, 8'hA0, 1, 1, 8'hB0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("alt_grant_a", bus.grant_a, 32'(i % 2 == 0));
      check("alt_grant_b", bus.grant_b, 32'(i % 2 == 1));
      check("alt_sel", bus.sel, 32'(i % 2));
      if (i > 0) check("alt_valid", bus.valid, 1);
      if (i > 0) check("alt_y", bus.y, (i % 2 == 1) ? 8'hA0 : 8'hB0);
    end
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    tick(); tick();

    // Hold limit under contention: exactly MH A beats then hand over to B.
    do_reset();
    drive(1, 8'h5A, 0, 1, 8'hC3, 0);
    for (int i = 1; i <= MH; i++) begin
      tick();
      check("hold_grant_a", bus.grant_a, 1);
    end
    tick();
    check("hold_handover_b", bus.grant_b, 1);
    check("hold_last_a_beat", bus.y, 8'h5A);

    // Hold limit without contention: A keeps the grant well past MH beats.
    do_reset();
    drive(1, 8'h77, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3 * MH; i++) tick();
    check("hold_alone_grant_a", bus.grant_a, 1);
    check("hold_alone_valid", bus.valid, 1);

    // Reset in the middle of a B packet, then a tie must go to A.
    do_reset();
    drive(0, 8'h00, 0, 1, 8'h9C, 0);
    tick(); tick();
    check("midpkt_grant_b", bus.grant_b, 1);
    rst = 1'b1;
    tick();
    check("midpkt_rst_grant_b", bus.grant_b, 0);
    check("midpkt_rst_valid", bus.valid, 0);
    check("midpkt_rst_y", bus.y, 0);
    check("midpkt_rst_sel", bus.sel, 0);
    rst = 1'b0;
    drive(1, 8'h12, 1, 1, 8'h34, 1);
    tick();
    check("midpkt_tie_to_a", bus.grant_a, 1);
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    tick(); tick();

    // Three A packets and two B packets.
    do_reset();
    drive(1, 8'h01, 1, 1, 8'h02, 1);
    for (int i = 0; i < 5; i++) tick();
    drive(1, 8'h01, 1, 0, 8'h02, 1);
    tick();
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    tick();
`ifdef ARB_MUX2_STATS_EN
    check("stats_cnt_a", bus.cnt_a, 3);
    check("stats_cnt_b", bus.cnt_b, 2);
`else
    check("stats_cnt_a_off", bus.cnt_a, 0);
    check("stats_cnt_b_off", bus.cnt_b, 0);
`endif

    // Random traffic with sticky requests and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) bus.req_a = ~bus.req_a;
      if ($urandom_range(0, 3) == 0) bus.req_b = ~bus.req_b;
      bus.data_a = 8'($urandom);
      bus.data_b = 8'($urandom);
      bus.last_a = ($urandom_range(0, 2) == 0);
      bus.last_b = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
